// File: rtl/timer_counter_dev_pkg.sv
// Shared definitions for the memory-mapped timer/counter devices: base
// addresses, register word offsets, CTRL field layout, MODE encodings and
// the FSM state encoding.
package timer_counter_dev_pkg;

  // Device base addresses, also used by the M-stage address checker
  localparam logic [31:0] TC0_BASE = 32'h0000_7F00;
  localparam logic [31:0] TC1_BASE = 32'h0000_7F10;

  // Register word offsets, expressed as addr[3:2]
  localparam logic [1:0] OFF_CTRL   = 2'd0;  // +0x0
  localparam logic [1:0] OFF_PRESET = 2'd1;  // +0x4
  localparam logic [1:0] OFF_COUNT  = 2'd2;  // +0x8
  localparam logic [1:0] OFF_RSVD   = 2'd3;  // +0xC, reads zero

  // CTRL bit positions
  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_IM_BIT   = 3;
  localparam int CTRL_W        = 4;

  // MODE encodings; 2'b1x behaves as one-shot
  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_AUTO    = 2'b01;

  // Stored CTRL bits, MSB first so the packed value matches the register layout
  typedef struct packed {
    logic       im;
    logic [1:0] mode;
    logic       en;
  } tc_ctrl_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } tc_state_e;

  // True when a byte address falls inside the 16-byte window at base
  function automatic logic tc_hit(input logic [31:0] addr, input logic [31:0] base);
    return addr[31:4] == base[31:4];
  endfunction

endpackage

// File: rtl/timer_counter_dev.sv
// Timer/counter peripheral: CTRL/PRESET/COUNT word registers, a four-state
// count-down FSM and a combinational read mux. Counts PRESET down to zero and
// flags an interrupt, either once (one-shot) or periodically (auto-reload).
module timer_counter_dev
  import timer_counter_dev_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = TC0_BASE,
  parameter int          CNT_W     = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  tc_ctrl_t           ctrl;
  logic [CNT_W-1:0]   preset;
  logic [CNT_W-1:0]   count;
  tc_state_e          state;
  logic               irq_flag;

  logic sel;
  logic wr_ctrl;
  logic wr_preset;

  assign sel       = tc_hit(addr, BASE_ADDR);
  assign wr_ctrl   = we & sel & (addr[3:2] == OFF_CTRL);
  assign wr_preset = we & sel & (addr[3:2] == OFF_PRESET);

  // Byte-lane bits and upper write-data bits have no storage behind them
  logic unused_bits;
  assign unused_bits = ^{addr[1:0], wdata};

  // PRESET register: only the CPU writes it
  // NOTE: sequential state always uses non-blocking (<=) so every flop samples
  // pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      preset <= '0;
    end else if (wr_preset) begin
      preset <= wdata[CNT_W-1:0];
    end
  end

  // Count-down FSM together with CTRL, COUNT and the interrupt flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      ctrl     <= '0;
      count    <= '0;
      irq_flag <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (ctrl.en) state <= ST_LOAD;
        end
        ST_LOAD: begin
          count <= preset;
          state <= ST_CNT;
        end
        ST_CNT: begin
          if (!ctrl.en) begin
            state <= ST_IDLE;
          end else if (count > CNT_W'(1)) begin
            count <= count - CNT_W'(1);
          end else begin
            count    <= '0;
            irq_flag <= 1'b1;
            state    <= ST_INT;
          end
        end
        ST_INT: begin
          if (ctrl.mode == MODE_AUTO) begin
            irq_flag <= 1'b0;
          end else begin
            ctrl.en <= 1'b0;
          end
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase

      // NOTE: the CPU write is placed after the FSM so its non-blocking
      // assignments land last and win over any same-cycle FSM update.
      if (wr_ctrl) begin
        ctrl     <= tc_ctrl_t'(wdata[CTRL_W-1:0]);
        irq_flag <= 1'b0;
      end
    end
  end

  // Read mux, decoded from the word offset only
  // NOTE: rdata gets a default first so no path through the case infers a latch.
  always_comb begin
    rdata = '0;
    case (addr[3:2])
      OFF_CTRL:   rdata = {{(32-CTRL_W){1'b0}}, ctrl};
      OFF_PRESET: rdata = 32'(preset);
      OFF_COUNT:  rdata = 32'(count);
      default:    rdata = '0;
    endcase
  end

  // Masking gates the output only; the flag itself is untouched by IM
  assign irq = irq_flag & ctrl.im;

endmodule

// File: tb/tb_timer_counter_dev.sv
// Directed bench for timer_counter_dev: a per-cycle vector table for reset,
// decode and one-shot behaviour, then hand-written multi-cycle sequences.
module tb_timer_counter_dev;

  localparam logic [31:0] A_CTRL   = 32'h0000_7F00;
  localparam logic [31:0] A_PRESET = 32'h0000_7F04;
  localparam logic [31:0] A_COUNT  = 32'h0000_7F08;
  localparam logic [31:0] A_RSVD   = 32'h0000_7F0C;
  localparam logic [31:0] A_OTHER  = 32'h0000_7F14;

  logic        clk;
  logic        reset;
  logic [31:0] addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  int n_cmp  = 0;
  int n_fail = 0;

  timer_counter_dev #(
    .BASE_ADDR(32'h0000_7F00),
    .CNT_W    (32)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .addr (addr),
    .we   (we),
    .wdata(wdata),
    .rdata(rdata),
    .irq  (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chk;
    logic [31:0] exp_rdata;
    logic        exp_irq;
    string       name;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic c, input logic [31:0] er, input logic ei,
                     input string nm);
    vec_t v;
    v.we = w; v.addr = a; v.wdata = d; v.chk = c;
    v.exp_rdata = er; v.exp_irq = ei; v.name = nm;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One-cycle register write; returns just after the edge with we low
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    we = 1'b1; addr = a; wdata = d;
    cyc();
    we = 1'b0;
  endtask

  task automatic rd_check(input logic [31:0] a, input logic [31:0] exp, input string name);
    we = 1'b0; addr = a;
    #1;
    check(name, rdata, exp);
  endtask

  // Wait (bounded) until COUNT reads v; ends 2 time units after an edge
  task automatic wait_count(input logic [31:0] v, input string name);
    logic found;
    found = 1'b0;
    we = 1'b0; addr = A_COUNT;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #2;
      if (rdata === v) begin
        found = 1'b1;
        break;
      end
    end
    check(name, {31'b0, found}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; we = 1'b0; addr = '0; wdata = '0;

    // Reset, decode and a complete one-shot run with IM=1, one vector per cycle
    add(0, A_CTRL,   0,     1, 32'h0, 0, "rst_ctrl");
    add(0, A_PRESET, 0,     1, 32'h0, 0, "rst_preset");
    add(0, A_COUNT,  0,     1, 32'h0, 0, "rst_count");
    add(0, A_RSVD,   0,     1, 32'h0, 0, "rst_rsvd");
    add(1, A_COUNT,  32'h1234, 1, 32'h0, 0, "wr_count_rdata");
    add(0, A_COUNT,  0,     1, 32'h0, 0, "count_after_wr");
    add(1, A_OTHER,  32'hF, 0, 32'h0, 0, "wr_other_dev");
    add(0, A_PRESET, 0,     1, 32'h0, 0, "preset_after_other");
    add(1, A_PRESET, 32'd5, 1, 32'h0, 0, "wr_preset5");
    add(1, A_CTRL,   32'h9, 1, 32'h0, 0, "wr_ctrl9");
    add(0, A_COUNT,  0,     1, 32'd0, 0, "os_idle");
    add(0, A_COUNT,  0,     1, 32'd0, 0, "os_load");
    add(0, A_COUNT,  0,     1, 32'd5, 0, "os_cnt5");
    add(0, A_COUNT,  0,     1, 32'd4, 0, "os_cnt4");
    add(0, A_COUNT,  0,     1, 32'd3, 0, "os_cnt3");
    add(0, A_COUNT,  0,     1, 32'd2, 0, "os_cnt2");
    add(0, A_COUNT,  0,     1, 32'd1, 0, "os_cnt1");
    add(0, A_COUNT,  0,     1, 32'd0, 1, "os_int");
    add(0, A_CTRL,   0,     1, 32'h8, 1, "os_en_cleared");
    add(0, A_COUNT,  0,     1, 32'd0, 1, "os_irq_held");
    add(1, A_CTRL,   32'h8, 1, 32'h8, 1, "os_wr_clear");
    add(0, A_CTRL,   0,     1, 32'h8, 0, "os_ctrl_after_clr");
    add(0, A_COUNT,  0,     1, 32'd0, 0, "os_irq_cleared");

    #22 reset = 1'b1;
    cyc();

    for (int i = 0; i < vecs.size(); i++) begin
      we = vecs[i].we; addr = vecs[i].addr; wdata = vecs[i].wdata;
      #1;
      if (vecs[i].chk) begin
        check({vecs[i].name, ".rdata"}, rdata, vecs[i].exp_rdata);
        check({vecs[i].name, ".irq"}, {31'b0, irq}, {31'b0, vecs[i].exp_irq});
      end
      cyc();
    end
    we = 1'b0;

    // Auto-reload, PRESET=3: irq high in cycles 5, 11, 17, 23 after the CTRL write
    wr(A_PRESET, 32'd3);
    wr(A_CTRL, 32'hB);
    addr = A_CTRL;
    for (int k = 1; k <= 26; k++) begin
      logic exp_i;
      @(posedge clk);
      #2;
      exp_i = (k >= 5) && (((k - 5) % 6) == 0);
      check($sformatf("ar_irq_k%0d", k), {31'b0, irq}, {31'b0, exp_i});
      check($sformatf("ar_ctrl_k%0d", k), rdata, 32'hB);
    end
    wr(A_CTRL, 32'h0);
    cyc(); cyc();

    // Disable mid-count: write lands while COUNT=8, so COUNT settles at 7
    wr(A_PRESET, 32'd10);
    wr(A_CTRL, 32'h1);
    wait_count(32'd8, "mid_reach8");
    wr(A_CTRL, 32'h0);
    rd_check(A_COUNT, 32'd7, "mid_count7");
    for (int k = 0; k < 3; k++) begin
      cyc();
      rd_check(A_COUNT, 32'd7, $sformatf("mid_frozen%0d", k));
    end
    wr(A_CTRL, 32'h1);
    rd_check(A_COUNT, 32'd7, "reen_idle");
    cyc();
    rd_check(A_COUNT, 32'd7, "reen_load");
    cyc();
    rd_check(A_COUNT, 32'd10, "reen_reload10");
    wr(A_CTRL, 32'h0);
    cyc(); cyc();

    // Masked one-shot: flag sets internally, irq output never rises
    wr(A_PRESET, 32'd5);
    wr(A_CTRL, 32'h1);
    for (int k = 1; k <= 12; k++) begin
      cyc();
      #1;
      check($sformatf("mask_irq_k%0d", k), {31'b0, irq}, 32'd0);
    end
    check("mask_flag_set", {31'b0, dut.irq_flag}, 32'd1);
    rd_check(A_CTRL, 32'h0, "mask_en_cleared");
    wr(A_CTRL, 32'h9);
    #1;
    check("mask_irq_after_wr9", {31'b0, irq}, 32'd0);
    check("mask_flag_cleared", {31'b0, dut.irq_flag}, 32'd0);
    wr(A_CTRL, 32'h0);
    cyc(); cyc(); cyc();

    // PRESET 0 and 1: LOAD, a single CNT cycle, then INT
    for (int p = 0; p <= 1; p++) begin
      wr(A_PRESET, 32'(p));
      wr(A_CTRL, 32'h9);
      cyc();
      cyc();
      rd_check(A_COUNT, 32'(p), $sformatf("p%0d_cnt", p));
      check($sformatf("p%0d_irq_lo", p), {31'b0, irq}, 32'd0);
      cyc();
      rd_check(A_COUNT, 32'd0, $sformatf("p%0d_int_count", p));
      check($sformatf("p%0d_irq_hi", p), {31'b0, irq}, 32'd1);
      cyc();
      rd_check(A_CTRL, 32'h8, $sformatf("p%0d_ctrl", p));
      wr(A_CTRL, 32'h8);
    end

    // Asynchronous reset mid-count, then no resumption after release
    wr(A_PRESET, 32'd10);
    wr(A_CTRL, 32'h9);
    wait_count(32'd4, "rst_reach4");
    #1 reset = 1'b0;
    #1 check("arst_count", rdata, 32'd0);
    rd_check(A_CTRL, 32'h0, "arst_ctrl");
    check("arst_irq", {31'b0, irq}, 32'd0);
    rd_check(A_PRESET, 32'h0, "arst_preset");
    #1 reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cyc();
      rd_check(A_COUNT, 32'd0, $sformatf("post_rst_count%0d", k));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
